mempool_dma_req_arbiter: RTL and testbench

// - Shares the single cluster DMA request port (dma_req_t valid/ready) between NumReq frontends (control-register ports, cores).
// - Round-robin arbitration with grant lock until the downstream accepts.
// - Tracks up to MaxOutstanding in-flight transfers in issue order and routes each completion pulse back to the issuing requester.
// - Sits between the frontends and the cluster DMA request spill register.

---
 rtl/mempool_pkg.sv | 13 +
 rtl/mempool_dma_req_arbiter_id_fifo.sv | 49 ++++
 rtl/mempool_dma_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_mempool_dma_req_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mempool_pkg.sv
// Shared MemPool cluster types; the DMA burst request travels from the frontends
// through the arbiter to the cluster DMA request port.
package mempool_pkg;

  localparam int unsigned DmaAddrWidth = 32;

  typedef struct packed {
    logic [DmaAddrWidth-1:0] src;
    logic [DmaAddrWidth-1:0] dst;
    logic [DmaAddrWidth-1:0] num_bytes;
  } dma_req_t;

endpackage

// File: rtl/mempool_dma_req_arbiter_id_fifo.sv
// Outstanding-transfer ID FIFO: remembers, in issue order, which requester owns
// each in-flight DMA transfer so completions can be routed back.
module mempool_dma_req_arbiter_id_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic [AddrW:0]   usage_o
);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic [AddrW:0]   usage;

  // NOTE: storage is not reset; usage and the pointers define which entries are
  // valid, and the head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + AddrW'(1);
      if (pop_i)  rd_ptr <= rd_ptr + AddrW'(1);
      case ({push_i, pop_i})
        2'b10:   usage <= usage + (AddrW+1)'(1);
        2'b01:   usage <= usage - (AddrW+1)'(1);
        default: usage <= usage;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign empty_o = (usage == '0);
  assign usage_o = usage;

endmodule

// File: rtl/mempool_dma_req_arbiter.sv
// Round-robin arbiter sharing the cluster DMA request port between NumReq frontends,
// with grant lock until accepted and per-requester completion routing.
module mempool_dma_req_arbiter
  import mempool_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  dma_req_t [NumReq-1:0]            req_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  output dma_req_t                         dma_req_o,
  output logic                             dma_req_valid_o,
  input  logic                             dma_req_ready_i,
  input  logic                             trans_complete_i,
  output logic [NumReq-1:0]                done_o,
  output logic [NumReq-1:0][CntWidth-1:0]  issued_cnt_o,
  output logic [NumReq-1:0][CntWidth-1:0]  done_cnt_o,
  output logic [NumReq-1:0]                busy_o,
  output logic                             full_o,
  output logic                             err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned OccW = $clog2(MaxOutstanding) + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                          state_q, state_d;
  logic [IdxW-1:0]                 rr_q, gnt_q, pick;
  dma_req_t                        payload_q;
  logic [NumReq-1:0][CntWidth-1:0] issued_q, done_q;
  logic                            err_q;
  logic                            grant, handshake, pop, fifo_empty;
  logic [IdxW-1:0]                 head;
  logic [OccW-1:0]                 usage;

  // First valid requester at or after ptr, wrapping around.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] valid,
                                              input logic [IdxW-1:0]   ptr);
    logic [IdxW-1:0] sel;
    logic            found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (!found && valid[i] && i >= int'(ptr)) begin
        found = 1'b1;
        sel   = IdxW'(i);
      end
    end
    for (int i = 0; i < int'(NumReq); i++) begin
      if (!found && valid[i]) begin
        found = 1'b1;
        sel   = IdxW'(i);
      end
    end
    return sel;
  endfunction

  assign pick   = rr_pick(req_valid_i, rr_q);
  assign full_o = (usage == OccW'(MaxOutstanding));
  assign pop    = trans_complete_i && !fifo_empty;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    grant           = 1'b0;
    handshake       = 1'b0;
    req_ready_o     = '0;
    dma_req_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i && !full_o) begin
          grant   = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        dma_req_valid_o = 1'b1;
        if (dma_req_ready_i) begin
          handshake          = 1'b1;
          req_ready_o[gnt_q] = 1'b1;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      gnt_q     <= '0;
      payload_q <= '0;
      issued_q  <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant) begin
        gnt_q     <= pick;
        payload_q <= req_i[pick];
      end
      if (handshake) begin
        issued_q[gnt_q] <= issued_q[gnt_q] + CntWidth'(1);
        rr_q            <= (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + IdxW'(1);
      end
      if (pop) done_q[head] <= done_q[head] + CntWidth'(1);
      if (trans_complete_i && fifo_empty) err_q <= 1'b1;
    end
  end

  mempool_dma_req_arbiter_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (gnt_q),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .usage_o (usage)
  );

  always_comb begin
    done_o = '0;
    if (pop) done_o[head] = 1'b1;
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < int'(NumReq); i++) busy_o[i] = (issued_q[i] != done_q[i]);
  end

  assign dma_req_o    = payload_q;
  assign issued_cnt_o = issued_q;
  assign done_cnt_o   = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mempool_dma_req_arbiter.sv
// Self-checking bench for mempool_dma_req_arbiter: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mempool_dma_req_arbiter;
  import mempool_pkg::*;

  localparam int N   = 4;
  localparam int MAX = 8;
  localparam int CW  = 8;

  logic                      clk = 1'b0;
  logic                      rst_i = 1'b1;
  dma_req_t [N-1:0]          req = '0;
  logic [N-1:0]              req_valid = '0;
  logic [N-1:0]              req_ready_o;
  dma_req_t                  dma_req_o;
  logic                      dma_req_valid_o;
  logic                      ready = 1'b0;
  logic                      complete = 1'b0;
  logic [N-1:0]              done_o;
  logic [N-1:0][CW-1:0]      issued_cnt_o;
  logic [N-1:0][CW-1:0]      done_cnt_o;
  logic [N-1:0]              busy_o;
  logic                      full_o;
  logic                      err_o;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  mempool_dma_req_arbiter #(
    .NumReq         (N),
    .MaxOutstanding (MAX),
    .CntWidth       (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready_o),
    .dma_req_o        (dma_req_o),
    .dma_req_valid_o  (dma_req_valid_o),
    .dma_req_ready_i  (ready),
    .trans_complete_i (complete),
    .done_o           (done_o),
    .issued_cnt_o     (issued_cnt_o),
    .done_cnt_o       (done_cnt_o),
    .busy_o           (busy_o),
    .full_o           (full_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- reference model ----------------
  bit              m_locked;
  int              m_gnt;
  dma_req_t        m_payload;
  int              m_rr;
  int              q[$];
  logic [CW-1:0]   m_issued [N];
  logic [CW-1:0]   m_done [N];
  bit              m_err;

  task automatic model_step();
    bit was_full;
    bit found;
    int h;
    if (rst_i) begin
      m_locked  = 1'b0;
      m_gnt     = 0;
      m_payload = '0;
      m_rr      = 0;
      q.delete();
      for (int i = 0; i < N; i++) begin
        m_issued[i] = '0;
        m_done[i]   = '0;
      end
      m_err = 1'b0;
    end else begin
      was_full = (q.size() == MAX);
      if (complete) begin
        if (q.size() > 0) begin
          h = q.pop_front();
          m_done[h] = m_done[h] + 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_locked) begin
        if (ready) begin
          q.push_back(m_gnt);
          m_issued[m_gnt] = m_issued[m_gnt] + 1'b1;
          m_rr     = (m_gnt + 1) % N;
          m_locked = 1'b0;
        end
      end else if (req_valid != '0 && !was_full) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_rr + k) % N]) begin
            found = 1'b1;
            m_gnt = (m_rr + k) % N;
          end
        end
        m_locked  = 1'b1;
        m_payload = req[m_gnt];
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    logic [N-1:0] er, ed, eb;
    if (cmp_en) begin
      er = (m_locked && ready) ? oh(m_gnt) : '0;
      ed = (complete && q.size() > 0) ? oh(q[0]) : '0;
      eb = '0;
      for (int i = 0; i < N; i++) eb[i] = (m_issued[i] != m_done[i]);
      check("dma_valid", dma_req_valid_o, m_locked);
      if (m_locked) check("dma_payload", dma_req_o, m_payload);
      check("req_ready", req_ready_o, er);
      check("done", done_o, ed);
      for (int i = 0; i < N; i++) begin
        check("issued_cnt", issued_cnt_o[i], m_issued[i]);
        check("done_cnt", done_cnt_o[i], m_done[i]);
      end
      check("busy", busy_o, eb);
      check("full", full_o, q.size() == MAX);
      check("err", err_o, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic randomize_payloads();
    for (int i = 0; i < N; i++) req[i] = {$urandom, $urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, dma_req_valid_o, 1'b0);
    check({tag, "_payload"}, dma_req_o, '0);
    check({tag, "_ready"}, req_ready_o, '0);
    check({tag, "_done"}, done_o, '0);
    check({tag, "_issued"}, issued_cnt_o, '0);
    check({tag, "_donecnt"}, done_cnt_o, '0);
    check({tag, "_busy"}, busy_o, '0);
    check({tag, "_full"}, full_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid = '0;
    ready = 1'b0;
    complete = 1'b0;
    cycle();
    cmp_en = 1'b1;
    cycle();
    settle();
    check_all_zero("reset");
    rst_i = 1'b0;
  endtask

  task automatic issue_one(input int idx);
    int waited;
    bit seen;
    waited = 0;
    seen = 1'b0;
    req_valid = oh(idx);
    ready = 1'b1;
    while (!seen && waited < 8) begin
      settle();
      if (req_ready_o != '0) begin
        seen = 1'b1;
        check("order_issue", req_ready_o, oh(idx));
      end
      cycle();
      waited++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL order_issue_timeout: requester %0d never accepted within 8 cycles", idx);
    end
    req_valid = '0;
    ready = 1'b0;
  endtask

  int       gidx [8];
  int       gcyc [8];
  int       ngr;
  int       exp_order [5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] exp_done_seq [3] = '{4'b0010, 4'b1000, 4'b0010};
  dma_req_t saved;
  int       total;

  initial begin
    // reset state
    do_reset();

    // single requester 2
    randomize_payloads();
    req_valid = 4'b0100;
    ready = 1'b1;
    saved = req[2];
    settle();
    check("single_c0_valid", dma_req_valid_o, 1'b0);
    cycle();
    settle();
    check("single_c1_valid", dma_req_valid_o, 1'b1);
    check("single_c1_ready", req_ready_o, 4'b0100);
    check("single_c1_payload", dma_req_o, saved);
    cycle();
    req_valid = '0;
    settle();
    check("single_issued2", issued_cnt_o[2], 8'd1);
    check("single_busy", busy_o, 4'b0100);
    cycle();

    // all requesters valid: round-robin order and rate
    do_reset();
    req_valid = 4'hF;
    ready = 1'b1;
    ngr = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (req_ready_o != '0) begin
        if (ngr < 8) begin
          gidx[ngr] = oh_idx(req_ready_o);
          gcyc[ngr] = c;
        end
        ngr++;
      end
      cycle();
    end
    req_valid = '0;
    check("rr_grant_count", ngr, 5);
    for (int k = 0; k < 5; k++) begin
      check("rr_grant_idx", gidx[k], exp_order[k]);
      check("rr_grant_cycle", gcyc[k], 2 * k + 1);
    end
    cycle();

    // backpressure while locked
    do_reset();
    randomize_payloads();
    req_valid = 4'hF;
    ready = 1'b0;
    saved = req[0];
    settle();
    check("bp_c0_valid", dma_req_valid_o, 1'b0);
    cycle();
    for (int k = 1; k <= 5; k++) begin
      randomize_payloads();
      settle();
      check("bp_valid", dma_req_valid_o, 1'b1);
      check("bp_hold", dma_req_o, saved);
      check("bp_no_ready", req_ready_o, '0);
      cycle();
    end
    ready = 1'b1;
    settle();
    check("bp_accept", req_ready_o, 4'b0001);
    check("bp_hold_accept", dma_req_o, saved);
    cycle();
    req_valid = '0;
    ready = 1'b0;
    cycle();

    // fill the outstanding FIFO
    do_reset();
    req_valid = 4'hF;
    ready = 1'b1;
    for (int c = 0; c < 20; c++) cycle();
    settle();
    total = 0;
    for (int i = 0; i < N; i++) total += int'(issued_cnt_o[i]);
    check("full_issued_total", total, 8);
    check("full_flag", full_o, 1'b1);
    check("full_no_valid", dma_req_valid_o, 1'b0);
    cycle();
    complete = 1'b1;
    settle();
    check("full_done_first", done_o, 4'b0001);
    cycle();
    complete = 1'b0;
    settle();
    check("full_cleared", full_o, 1'b0);
    cycle();
    settle();
    check("full_next_grant", req_ready_o, 4'b0001);
    cycle();
    req_valid = '0;
    ready = 1'b0;
    cycle();

    // issue order 1,3,1 then three completions
    do_reset();
    issue_one(1);
    issue_one(3);
    issue_one(1);
    for (int k = 0; k < 3; k++) begin
      complete = 1'b1;
      settle();
      check("order_done", done_o, exp_done_seq[k]);
      cycle();
      complete = 1'b0;
      cycle();
    end
    settle();
    check("order_donecnt1", done_cnt_o[1], 8'd2);
    check("order_donecnt3", done_cnt_o[3], 8'd1);
    check("order_busy", busy_o, '0);
    cycle();

    // completion with nothing in flight, then reset mid-lock
    complete = 1'b1;
    cycle();
    complete = 1'b0;
    settle();
    check("err_set", err_o, 1'b1);
    cycle();
    cycle();
    cycle();
    settle();
    check("err_sticky", err_o, 1'b1);
    cycle();
    req_valid = 4'b0001;
    ready = 1'b0;
    cycle();
    settle();
    check("midlock_valid", dma_req_valid_o, 1'b1);
    cycle();
    rst_i = 1'b1;
    req_valid = '0;
    cycle();
    settle();
    check_all_zero("reset_midlock");
    rst_i = 1'b0;
    cycle();

    // randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      randomize_payloads();
      req_valid = N'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      if ((i / 500) % 2 == 1) complete = ($urandom_range(0, 9) == 0);
      else                    complete = ($urandom_range(0, 9) < 4);
      cycle();
    end
    req_valid = '0;
    ready = 1'b0;
    complete = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
